ocm_debug_scan_master: RTL
==========================

# ocm_debug_scan_master

Simulation-side JTAG scan initiator for the on-chip debug path. It drives the virtual-JTAG signal set that the Nios II CPU debug slave consumes: tck, tdi, the virtual state strobes and ir_in. It also samples tdo and ir_out. Each accepted command performs one IR update followed by one full DR scan, and returns the shifted-out DR contents. It replaces the tied-off virtual-JTAG stubs in the simulation testbench, so debug commands (ocimem, break, tracectrl) can be exercised without a physical JTAG cable.

## Interface
Parameters:
- `TCK_DIV`, default 2: clk cycles per tck half-period; must be ≥ 1.
- `IR_WIDTH`, default 2: width of the instruction register.
- `DR_WIDTH`, default 38: width of the data register.

Ports:
- `clk`, in, 1: system clock. One clock; reset is synchronous and active-high.
- `reset`, in, 1: synchronous active-high reset.
- `cmd_valid`, in, 1: a scan command is offered.
- `cmd_ready`, out, 1: the block can accept a command (high only in IDLE).
- `cmd_ir`, in, IR_WIDTH: instruction value presented on ir_in.
- `cmd_dr`, in, DR_WIDTH: data shifted out on tdi, LSB first.
- `rsp_valid`, out, 1: the scan result is available.
- `rsp_ready`, in, 1: the consumer accepts the result.
- `rsp_dr`, out, DR_WIDTH: bits captured from tdo, LSB first.
- `rsp_ir_out`, out, IR_WIDTH: ir_out value sampled during UIR.
- `tck`, out, 1: generated test clock.
- `tdi`, out, 1: serial data to the slave.
- `tdo`, in, 1: serial data from the slave.
- `ir_in`, out, IR_WIDTH: instruction value to the slave.
- `ir_out`, in, IR_WIDTH: instruction-side status from the slave.
- `vs_uir`, out, 1: virtual state Update-IR.
- `vs_cdr`, out, 1: virtual state Capture-DR.
- `vs_sdr`, out, 1: virtual state Shift-DR.
- `vs_e1dr`, out, 1: virtual state Exit1-DR.
- `jtag_state_rti`, out, 1: Run-Test/Idle.

## Operation
- **Tick generator.** A counter runs only while a scan is active and counts TCK_DIV cycles per half-period. tck is low in the first half of each period and high in the second half. One "period" is 2·TCK_DIV clk cycles. The rising edge is the low→high transition; the falling edge is the period boundary.
- **States.** IDLE → UIR → CDR → SDR → E1DR → RTI → DONE → IDLE.
  - Each of UIR, CDR, E1DR and RTI lasts exactly one tck period.
  - SDR lasts DR_WIDTH periods.
  - The strobe for the current state is high for its whole duration.
- **Accept.** A handshake occurs when `cmd_valid && cmd_ready` in IDLE. cmd_ir and cmd_dr are latched at that point; later changes on the command inputs are ignored.
- **UIR.** ir_in = latched cmd_ir for UIR and all later states. ir_out is sampled into rsp_ir_out at the UIR rising edge.
- **SDR, bit i (0..DR_WIDTH−1).**
  - tdi = cmd_dr[i] for the whole period.
  - tdo is sampled into rsp_dr[i] at that period's rising edge.
  - Outside SDR, tdi = 0.
- **DONE.** tck is held low and all strobes are 0. rsp_valid = 1, and rsp_dr and rsp_ir_out are held stable until `rsp_ready`. On the handshake the block returns to IDLE on the next cycle.
- **Idle values.** In IDLE, ir_in keeps its last value (0 after reset).
- **Reset values.** cmd_ready = 1. All of the following are 0: rsp_valid, rsp_dr, rsp_ir_out, tck, tdi, ir_in, every vs_* strobe and jtag_state_rti.
- **Reset mid-scan.** The scan is aborted with no response, and all outputs take their reset values at the next edge.
- **Busy.** cmd_valid while not in IDLE is ignored; cmd_ready stays 0.

## Timing
- With the accept at cycle 0, UIR starts at cycle 1.
- rsp_valid rises at cycle 1 + (DR_WIDTH+4)·2·TCK_DIV. With the default parameters this is cycle 169.
- The earliest next accept is the cycle after the rsp handshake. The back-to-back minimum is (DR_WIDTH+4)·2·TCK_DIV + 2 cycles per command.
- Outputs are registered and have no combinational path from tdo. The one exception is cmd_ready, which is decoded from the state register.
- TCK_DIV = 1 must work: tck toggles every clk cycle.

## Structure
- Shared package `ocm_debug_jtag_pkg` contains:
  - the state enum `scan_state_t`;
  - the constants `OCM_IR_WIDTH = 2` and `OCM_DR_WIDTH = 38`;
  - named IR codes for the debug slave instructions, shared with the debug-slave bench.
- Sub-module `ocm_debug_tck_gen` contains the half-period counter. It outputs tck, a rise strobe and a period-end strobe, and is enabled by the FSM.
- The top level contains the FSM, the bit counter (ceil(log2 DR_WIDTH) bits), the tdi select and the tdo capture register.

## Test plan
- **Response data.** Issue IR=2'b10, DR=38'h0. A tdo model shifts out 38'h15_0000_00FF LSB first on tck falling edges. Required: rsp_dr = 38'h15_0000_00FF and rsp_valid at cycle 169.
- **Stimulus and strobes.** Issue DR=38'h2A_5555_AAAA. Required:
  - the tdi sequence at rising edges equals the DR, LSB first;
  - vs_sdr is high for exactly 152 clk cycles;
  - vs_uir, vs_cdr, vs_e1dr and jtag_state_rti are each high for 4 cycles, in that order.
- **ir_out capture.** Set ir_out = 2'b01 during UIR. Required: rsp_ir_out = 2'b01 and ir_in = 2'b10 from UIR onward.
- **Backpressure.** Hold rsp_ready low for 20 cycles after rsp_valid. Required: rsp_dr and rsp_ir_out are stable, cmd_ready = 0, and a cmd_valid pulse in that window is ignored.
- **Reset mid-scan.** Assert reset at SDR bit 10. Required: the next cycle shows all reset values and no rsp_valid, and a following command completes normally.
- **Minimum divider.** Set TCK_DIV=1, keep rsp_ready=1, and issue three back-to-back commands. Each completes in 86 cycles with the correct rsp_dr.

Source files
------------

// File: rtl/ocm_debug_jtag_pkg.sv
// Shared definitions for the on-chip debug virtual-JTAG path: scan FSM states,
// default register widths and the debug-slave instruction codes.
package ocm_debug_jtag_pkg;

  localparam int OCM_IR_WIDTH = 2;
  localparam int OCM_DR_WIDTH = 38;

  localparam logic [1:0] OCM_IR_OCIMEM    = 2'b00;
  localparam logic [1:0] OCM_IR_TRACEMEM  = 2'b01;
  localparam logic [1:0] OCM_IR_BREAK     = 2'b10;
  localparam logic [1:0] OCM_IR_TRACECTRL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_E1DR,
    ST_RTI,
    ST_DONE
  } scan_state_t;

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ocm_debug_tck_gen.sv
// Test-clock generator: tck low for the first TCK_DIV clk cycles of a period,
// high for the second; strobes flag the cycle before the rising edge and before the period end.
module ocm_debug_tck_gen
  import ocm_debug_jtag_pkg::*;
#(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic tck_o,
  output logic rise_o,
  output logic pend_o
);

  localparam int unsigned CW = cnt_width(2 * TCK_DIV);
  localparam logic [CW-1:0] RISE_AT = CW'(TCK_DIV - 1);
  localparam logic [CW-1:0] HALF    = CW'(TCK_DIV);
  localparam logic [CW-1:0] LAST    = CW'(2 * TCK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_q, tck_d;

  // tck is registered from the next count so it lines up with cnt_q exactly.
  always_comb begin
    cnt_d = '0;
    tck_d = 1'b0;
    if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      tck_d = (cnt_d >= HALF);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  assign tck_o  = tck_q;
  assign rise_o = en_i && (cnt_q == RISE_AT);
  assign pend_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/ocm_debug_scan_master.sv
// Virtual-JTAG scan initiator: per command, one IR update then one full DR scan,
// returning the bits shifted out of the debug slave.
module ocm_debug_scan_master
  import ocm_debug_jtag_pkg::*;
#(
  parameter int TCK_DIV  = 2,
  parameter int IR_WIDTH = OCM_IR_WIDTH,
  parameter int DR_WIDTH = OCM_DR_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  input  logic [IR_WIDTH-1:0] ir_out,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_e1dr,
  output logic                jtag_state_rti
);

  localparam int unsigned BW = cnt_width(DR_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DR_WIDTH - 1);

  scan_state_t         state_q;
  logic [DR_WIDTH-1:0] sh_q;
  logic [DR_WIDTH-1:0] rsp_dr_q;
  logic [IR_WIDTH-1:0] ir_in_q;
  logic [IR_WIDTH-1:0] rsp_ir_q;
  logic [BW-1:0]       bit_q;
  logic                tdi_q;
  logic                rsp_valid_q;
  logic                vs_uir_q, vs_cdr_q, vs_sdr_q, vs_e1dr_q, rti_q;

  logic scan_en, tck_rise, tck_pend;

  assign scan_en = (state_q != ST_IDLE) && (state_q != ST_DONE);

  ocm_debug_tck_gen #(
    .TCK_DIV(TCK_DIV)
  ) u_tck_gen (
    .clk   (clk),
    .reset (reset),
    .en_i  (scan_en),
    .tck_o (tck),
    .rise_o(tck_rise),
    .pend_o(tck_pend)
  );

  // Strobes and tdi change together with the state, at tck period boundaries.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ir_in_q     <= '0;
      rsp_ir_q    <= '0;
      rsp_dr_q    <= '0;
      bit_q       <= '0;
      tdi_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      vs_uir_q    <= 1'b0;
      vs_cdr_q    <= 1'b0;
      vs_sdr_q    <= 1'b0;
      vs_e1dr_q   <= 1'b0;
      rti_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            state_q  <= ST_UIR;
            ir_in_q  <= cmd_ir;
            sh_q     <= cmd_dr;
            vs_uir_q <= 1'b1;
          end
        end
        ST_UIR: begin
          if (tck_rise) rsp_ir_q <= ir_out;
          if (tck_pend) begin
            state_q  <= ST_CDR;
            vs_uir_q <= 1'b0;
            vs_cdr_q <= 1'b1;
          end
        end
        ST_CDR: begin
          if (tck_pend) begin
            state_q  <= ST_SDR;
            vs_cdr_q <= 1'b0;
            vs_sdr_q <= 1'b1;
            bit_q    <= '0;
            tdi_q    <= sh_q[0];
            sh_q     <= sh_q >> 1;
          end
        end
        ST_SDR: begin
          if (tck_rise) rsp_dr_q[bit_q] <= tdo;
          if (tck_pend) begin
            if (bit_q == LAST_BIT) begin
              state_q   <= ST_E1DR;
              vs_sdr_q  <= 1'b0;
              vs_e1dr_q <= 1'b1;
              tdi_q     <= 1'b0;
            end else begin
              bit_q <= bit_q + 1'b1;
              tdi_q <= sh_q[0];
              sh_q  <= sh_q >> 1;
            end
          end
        end
        ST_E1DR: begin
          if (tck_pend) begin
            state_q   <= ST_RTI;
            vs_e1dr_q <= 1'b0;
            rti_q     <= 1'b1;
          end
        end
        ST_RTI: begin
          if (tck_pend) begin
            state_q     <= ST_DONE;
            rti_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready      = (state_q == ST_IDLE);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_dr         = rsp_dr_q;
  assign rsp_ir_out     = rsp_ir_q;
  assign tdi            = tdi_q;
  assign ir_in          = ir_in_q;
  assign vs_uir         = vs_uir_q;
  assign vs_cdr         = vs_cdr_q;
  assign vs_sdr         = vs_sdr_q;
  assign vs_e1dr        = vs_e1dr_q;
  assign jtag_state_rti = rti_q;

endmodule
